stop_watch_disp_mux: RTL and testbench

- Display-side consumer of the stopwatch outputs.
- Takes the four BCD digits d3..d0 plus minus_flag and time-multiplexes them onto a 5-position common-bus 7-segment display (4 digit positions plus 1 sign position).
- Snapshots inputs once per scan frame so a frame never tears.
- Provides leading-zero blanking, per-digit decimal points and an inter-slot ghosting guard.

---
 rtl/stop_watch_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 33 +++
 rtl/stop_watch_disp_mux.sv | 139 +++++++++++++
 tb/tb_stop_watch_disp_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// Shared constants for the stopwatch display path: scan geometry and
// 7-segment glyphs. Glyphs are {g,f,e,d,c,b,a}, high-active; output polarity
// is applied once at the display mux output stage.
package stop_watch_pkg;

    localparam int NUM_POS  = 5;
    localparam int SIGN_POS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder; high-active {g..a} glyph out.
module seg7_decode
    import stop_watch_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    // Map the 4-bit value to its glyph; 10..15 show A,b,C,d,E,F.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_val)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stop_watch_disp_mux.sv
// Time-multiplexed 5-position 7-segment driver for the stopwatch.
// Scan order per frame is sign (slot 4) then digits 3..0, each slot 2^N
// cycles long with a GUARD-cycle dark window at its start. Inputs are
// snapshotted when a frame begins so a frame never mixes old and new values.
// The slot that reset lands in is a dark warm-up slot 4 (snapshot still
// zero); its wrap starts the first real frame, so the first frame_start
// arrives 2^N cycles after reset is released.
module stop_watch_disp_mux
    import stop_watch_pkg::*;
#(
    parameter int N          = 18,
    parameter int GUARD      = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         d3,
    input  logic [3:0]         d2,
    input  logic [3:0]         d1,
    input  logic [3:0]         d0,
    input  logic               minus_flag,
    input  logic               blank_lz,
    input  logic [3:0]         dp_en,
    output logic [NUM_POS-1:0] an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               frame_start
);

    localparam logic [N-1:0] PRESC_MAX = '1;
    localparam logic [N-1:0] GUARD_V   = N'(GUARD);
    localparam logic [2:0]   SIGN_SLOT = 3'(SIGN_POS);
    localparam logic         INV       = (ACTIVE_LOW != 0);

    logic [N-1:0]      r_presc;
    logic [2:0]        r_slot;
    logic              r_run;
    logic [3:0][3:0]   r_snap_d;
    logic              r_snap_minus;
    logic              r_snap_blz;
    logic [3:0]        r_snap_dp;

    logic              w_boundary;
    logic              w_new_frame;
    logic              w_blank3;
    logic              w_blank2;
    logic              w_blank1;
    logic [3:0]        w_val;
    logic              w_pos_blank;
    logic [6:0]        w_glyph;
    logic [6:0]        w_seg_hi;
    logic              w_dp_hi;
    logic [NUM_POS-1:0] w_an_hi;

    assign w_boundary  = (r_presc == PRESC_MAX);
    assign w_new_frame = w_boundary && (!r_run || (r_slot == 3'd0));

    // Prescaler, slot sequencing, frame snapshot and frame_start pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc      <= '0;
            r_slot       <= SIGN_SLOT;
            r_run        <= 1'b0;
            r_snap_d     <= '0;
            r_snap_minus <= 1'b0;
            r_snap_blz   <= 1'b0;
            r_snap_dp    <= '0;
            frame_start  <= 1'b0;
        end else begin
            r_presc     <= r_presc + 1'b1;
            frame_start <= w_new_frame;
            if (w_boundary) begin
                r_run <= 1'b1;
                if (w_new_frame) begin
                    r_slot       <= SIGN_SLOT;
                    r_snap_d     <= {d3, d2, d1, d0};
                    r_snap_minus <= minus_flag;
                    r_snap_blz   <= blank_lz;
                    r_snap_dp    <= dp_en;
                end else begin
                    r_slot <= r_slot - 3'd1;
                end
            end
        end
    end

    // Leading-zero blanking ripples rightwards from the thousands digit.
    assign w_blank3 = r_snap_blz && (r_snap_d[3] == 4'd0);
    assign w_blank2 = w_blank3 && (r_snap_d[2] == 4'd0);
    assign w_blank1 = w_blank2 && (r_snap_d[1] == 4'd0);

    // Select the digit value and its blanking flag for the current slot.
    always_comb begin
        w_val       = 4'd0;
        w_pos_blank = 1'b1;
        case (r_slot)
            3'd3: begin w_val = r_snap_d[3]; w_pos_blank = w_blank3; end
            3'd2: begin w_val = r_snap_d[2]; w_pos_blank = w_blank2; end
            3'd1: begin w_val = r_snap_d[1]; w_pos_blank = w_blank1; end
            3'd0: begin w_val = r_snap_d[0]; w_pos_blank = 1'b0;     end
            default: begin w_val = 4'd0; w_pos_blank = 1'b1; end
        endcase
    end

    seg7_decode u_dec (
        .i_val (w_val),
        .o_seg (w_glyph)
    );

    // High-active glyph, decimal point and anode for the current slot.
    always_comb begin
        if (r_slot == SIGN_SLOT) begin
            w_seg_hi = r_snap_minus ? SEG_MINUS : SEG_BLANK;
            w_dp_hi  = 1'b0;
        end else begin
            w_seg_hi = w_pos_blank ? SEG_BLANK : w_glyph;
            w_dp_hi  = r_snap_dp[r_slot[1:0]];
        end
        if (r_presc < GUARD_V) begin
            w_an_hi = '0;
        end else begin
            w_an_hi = {{(NUM_POS-1){1'b0}}, 1'b1} << r_slot;
        end
    end

    // Registered outputs with display polarity applied here only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= {NUM_POS{INV}};
            seg <= {7{INV}};
            dp  <= INV;
        end else begin
            an  <= w_an_hi ^ {NUM_POS{INV}};
            seg <= w_seg_hi ^ {7{INV}};
            dp  <= w_dp_hi ^ INV;
        end
    end

endmodule

// File: tb/tb_stop_watch_disp_mux.sv
// Self-checking bench for stop_watch_disp_mux (N=2, GUARD=1, active-low).
// The reference model works from "edges since reset release": a 4-cycle
// warm-up slot, then 20-cycle frames of sign, d3, d2, d1, d0 slots.
module tb_stop_watch_disp_mux;

    localparam int TB_N     = 2;
    localparam int SLOT_LEN = 1 << TB_N;
    localparam int FRAME    = 5 * SLOT_LEN;
    localparam int TB_GUARD = 1;

    logic       clk;
    logic       reset;
    logic [3:0] d3, d2, d1, d0;
    logic       minus_flag;
    logic       blank_lz;
    logic [3:0] dp_en;
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int tests = 0;
    int fails = 0;
    int e     = 0;

    // model snapshot of the frame currently on display
    logic [3:0] s_d [4];
    logic       s_minus;
    logic       s_blz;
    logic [3:0] s_dp;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    stop_watch_disp_mux #(.N(TB_N), .GUARD(TB_GUARD), .ACTIVE_LOW(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .d3          (d3),
        .d2          (d2),
        .d1          (d1),
        .d0          (d0),
        .minus_flag  (minus_flag),
        .blank_lz    (blank_lz),
        .dp_en       (dp_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp_v);
        end
    endtask

    // Slot / prescaler position of the state that exists after k edges.
    function automatic int slot_of(input int k);
        if (k < SLOT_LEN) return 4;
        return 4 - ((k - SLOT_LEN) % FRAME) / SLOT_LEN;
    endfunction

    function automatic int presc_of(input int k);
        if (k < SLOT_LEN) return k;
        return (k - SLOT_LEN) % SLOT_LEN;
    endfunction

    function automatic bit is_frame_edge(input int k);
        return (k >= SLOT_LEN) && (((k - SLOT_LEN) % FRAME) == 0);
    endfunction

    // Expected active-low outputs produced from the state after k edges.
    task automatic model_out(input int k, output logic [4:0] ean,
                             output logic [6:0] eseg, output logic edp);
        int         slot;
        int         presc;
        logic [4:0] a_hi;
        logic [6:0] s_hi;
        logic       d_hi;
        logic       all_zero;
        slot  = slot_of(k);
        presc = presc_of(k);
        a_hi  = (presc < TB_GUARD) ? 5'b00000 : 5'(1 << slot);
        if (slot == 4) begin
            s_hi = s_minus ? 7'h40 : 7'h00;
            d_hi = 1'b0;
        end else begin
            // blank when enabled, not the units digit, and this digit and all to its left are 0
            all_zero = 1'b1;
            for (int p = 3; p >= slot; p--) if (s_d[p] != 4'd0) all_zero = 1'b0;
            s_hi = (s_blz && slot != 0 && all_zero) ? 7'h00 : glyph_tab[s_d[slot]];
            d_hi = s_dp[slot];
        end
        ean  = ~a_hi;
        eseg = ~s_hi;
        edp  = ~d_hi;
    endtask

    task automatic step();
        logic [4:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic       efs;
        bit         cap;
        bit         in_rst;
        int         k;
        k      = e;
        in_rst = (reset == 1'b0);
        if (in_rst) begin
            ean = 5'h1F; eseg = 7'h7F; edp = 1'b1; efs = 1'b0; cap = 1'b0;
        end else begin
            model_out(k, ean, eseg, edp);
            efs = is_frame_edge(k + 1);
            cap = efs;
        end
        if (cap) begin
            s_d[3] = d3; s_d[2] = d2; s_d[1] = d1; s_d[0] = d0;
            s_minus = minus_flag; s_blz = blank_lz; s_dp = dp_en;
        end
        @(posedge clk);
        if (in_rst) begin
            e = 0;
            for (int p = 0; p < 4; p++) s_d[p] = 4'd0;
            s_minus = 1'b0; s_blz = 1'b0; s_dp = 4'd0;
        end else begin
            e = k + 1;
        end
        #1;
        check("an", {3'b0, an}, {3'b0, ean});
        check("seg", {1'b0, seg}, {1'b0, eseg});
        check("dp", {7'b0, dp}, {7'b0, edp});
        check("frame_start", {7'b0, frame_start}, {7'b0, efs});
        check("an_onehot", {7'b0, ($countones(~an) <= 1)}, 8'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_in(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                          input logic [3:0] a0, input logic mf, input logic blz,
                          input logic [3:0] dpe);
        d3 = a3; d2 = a2; d1 = a1; d0 = a0;
        minus_flag = mf; blank_lz = blz; dp_en = dpe;
    endtask

    // Step until the model is inside the given slot of a running frame (bounded).
    task automatic run_to_slot(input int slot);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (e >= SLOT_LEN && slot_of(e) == slot) return;
            step();
        end
        tests++;
        fails++;
        $error("FAIL run_to_slot: slot %0d not reached, observed edge=%0d", slot, e);
    endtask

    initial begin
        reset = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        for (int p = 0; p < 4; p++) s_d[p] = 4'd0;
        s_minus = 1'b0; s_blz = 1'b0; s_dp = 4'd0;

        // reset held for three cycles
        run(3);
        reset = 1'b1;

        // scan order with plain digits; warm-up slot then two frames
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'b0000);
        run(SLOT_LEN + 2 * FRAME);

        // leading-zero blanking variants
        set_in(4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 4'b0000);
        run(2 * FRAME);
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'b0000);
        run(2 * FRAME);
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000);
        run(2 * FRAME);

        // sign and decimal point
        set_in(4'd9, 4'd8, 4'd7, 4'd6, 1'b1, 1'b0, 4'b0100);
        run(2 * FRAME);

        // no tearing: change d0 while slot 2 is on display
        set_in(4'd1, 4'd0, 4'd2, 4'd3, 1'b0, 1'b1, 4'b0001);
        run(FRAME);
        run_to_slot(2);
        d0 = 4'd7;
        run(2 * FRAME);

        // hex glyph
        set_in(4'd0, 4'd0, 4'hE, 4'hB, 1'b1, 1'b1, 4'b1010);
        run(2 * FRAME);

        // randomized inputs changing at random points
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)));
            end
            step();
        end

        // mid-frame reset in slot 1, then recovery and first frame_start timing
        set_in(4'd3, 4'd1, 4'd4, 4'd1, 1'b1, 1'b0, 4'b1111);
        run_to_slot(1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        run(SLOT_LEN + 2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
